// File: rtl/mips_hazard_scoreboard_if.sv
// rtl/mips_hazard_scoreboard_if.sv - D-stage issue / hazard-response bundle for mips_hazard_scoreboard
//
// master : D-stage issue logic (drives the candidate instruction, receives stall/bypass)
// slave  : mips_hazard_scoreboard
//   issue_valid / issue_wen / issue_waddr / issue_lat : candidate instruction and its producer latency
//   issue_rd_addr / issue_rd_used                       : NRD source ports, port p at [p*AW +: AW]
//   flush                                               : squash the D-stage instruction this cycle
//   stall / fwd_sel                                     : hold F/D, per-port bypass select (port p at [p*SW +: SW])
interface mips_hazard_scoreboard_if #(
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int SW  = 3
);
    logic               issue_valid;
    logic               issue_wen;
    logic [AW-1:0]      issue_waddr;
    logic [SW-1:0]      issue_lat;
    logic [NRD*AW-1:0]  issue_rd_addr;
    logic [NRD-1:0]     issue_rd_used;
    logic               flush;
    logic               stall;
    logic [NRD*SW-1:0]  fwd_sel;

    modport master (
        output issue_valid, issue_wen, issue_waddr, issue_lat,
        output issue_rd_addr, issue_rd_used, flush,
        input  stall, fwd_sel
    );

    modport slave (
        input  issue_valid, issue_wen, issue_waddr, issue_lat,
        input  issue_rd_addr, issue_rd_used, flush,
        output stall, fwd_sel
    );
endinterface

// File: rtl/mips_hazard_scoreboard.sv
// rtl/mips_hazard_scoreboard.sv - per-register pending-latency scoreboard with in-flight bypass tracker
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (slave)    : issue request from the D stage, stall and per-port bypass select back
//   pend_mask      : bit r set while register r still has cycles outstanding (bit 0 always 0)
//   perf_stall_cnt : saturating stall-cycle counter
// Optional feature macro: MIPS_HAZARD_SCOREBOARD_PERF_EN
//   defined   -> perf_stall_cnt counts stall cycles, saturating at 32'hFFFF_FFFF
//   undefined -> perf_stall_cnt is tied to 0
module mips_hazard_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int DEPTH = 4,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    mips_hazard_scoreboard_if.slave  bus,
    output logic [NREG-1:0]          pend_mask,
    output logic [31:0]              perf_stall_cnt
);

    logic [SW-1:0] cnt   [NREG];
    logic          trk_v [1:DEPTH];
    logic [AW-1:0] trk_a [1:DEPTH];

    logic [SW-1:0] lat_sat;
    logic          raw, waw, acc, wr_track;

    // Out-of-range latencies are clamped so the counter never outlives the tracker.
    assign lat_sat  = (bus.issue_lat > SW'(DEPTH)) ? SW'(DEPTH) : bus.issue_lat;
    assign wr_track = bus.issue_wen && (bus.issue_waddr != '0);

    always_comb begin
        raw = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (bus.issue_rd_used[p] && (bus.issue_rd_addr[p*AW +: AW] != '0)
                && (cnt[bus.issue_rd_addr[p*AW +: AW]] != '0))
                raw = 1'b1;
        end
        raw = raw && bus.issue_valid;
        // A younger write may only proceed if it cannot retire ahead of the older one.
        waw = bus.issue_valid && wr_track && (cnt[bus.issue_waddr] > lat_sat);
    end

    assign bus.stall = (raw || waw) && !bus.flush;
    assign acc       = bus.issue_valid && !bus.stall && !bus.flush;

    // Per-port bypass: the youngest matching in-flight stage wins.
    always_comb begin
        bus.fwd_sel = '0;
        for (int p = 0; p < NRD; p++) begin
            for (int k = DEPTH; k >= 1; k--) begin
                if (trk_v[k] && (trk_a[k] == bus.issue_rd_addr[p*AW +: AW]))
                    bus.fwd_sel[p*SW +: SW] = SW'(k);
            end
            if (!bus.issue_rd_used[p] || (bus.issue_rd_addr[p*AW +: AW] == '0))
                bus.fwd_sel[p*SW +: SW] = '0;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int r = 1; r < NREG; r++)
            pend_mask[r] = (cnt[r] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (acc && wr_track && (bus.issue_waddr == AW'(r)))
                    cnt[r] <= lat_sat;
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Stalled or flushed issues enter as bubbles; the back end never stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= DEPTH; k++) begin
                trk_v[k] <= 1'b0;
                trk_a[k] <= '0;
            end
        end else begin
            trk_v[1] <= acc && wr_track;
            trk_a[1] <= bus.issue_waddr;
            for (int k = 2; k <= DEPTH; k++) begin
                trk_v[k] <= trk_v[k-1];
                trk_a[k] <= trk_a[k-1];
            end
        end
    end

`ifdef MIPS_HAZARD_SCOREBOARD_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall_cnt <= '0;
        else if (bus.stall && (perf_stall_cnt != 32'hFFFF_FFFF))
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`else
    assign perf_stall_cnt = 32'd0;
`endif

`ifndef SYNTHESIS
    lat_legal: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.issue_valid && (bus.issue_lat > SW'(DEPTH))));
`endif

endmodule

// File: doc/mips_hazard_scoreboard.md
Name: mips_hazard_scoreboard

Overview:
- Parametrised hazard and bypass controller for the in-order MIPS pipeline.
- Replaces fixed per-stage hazard decode with a per-register pending-latency scoreboard plus an in-flight write tracker.
- Supports producers of arbitrary latency (ALU, load, multi-cycle mul/div) and any number of source read ports.
- Sits beside the D-stage issue logic: stalls issue on RAW/WAW hazards and drives the select lines of the bypass muxes.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is hard-wired zero and never tracked.
- AW, 5, register address width; must satisfy 2**AW >= NREG.
- NRD, 2, number of source read ports checked per issue.
- DEPTH, 4, in-flight stages tracked after issue (E..W plus extra); also the maximum producer latency.
- SW, $clog2(DEPTH+1), width of the latency counter and of the bypass select.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction present in D stage
- issue_wen  in  1  instruction writes a GPR
- issue_waddr  in  AW  destination register
- issue_lat  in  SW  cycles before the result is bypassable; 0 = available to the next instruction
- issue_rd_addr  in  NRD*AW  source register addresses, port p at [p*AW +: AW]
- issue_rd_used  in  NRD  source port p is actually read
- flush  in  1  squash the D-stage instruction this cycle
- stall  out  1  hold F/D; insert a bubble into E
- fwd_sel  out  NRD*SW  per port: 0 = register file, k = youngest in-flight stage k (1..DEPTH)
- pend_mask  out  NREG  bit r set when cnt[r] != 0; bit 0 is always 0
- perf_stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset is asynchronous, active-low. On reset: all cnt[r] = 0, all tracker entries invalid, stall = 0, fwd_sel = 0, pend_mask = 0, perf_stall_cnt = 0.
- State:
  - cnt[1..NREG-1], each SW bits.
  - Tracker: DEPTH entries of {v, waddr}; entry 1 is the youngest.
- RAW hazard: issue_valid and some p with issue_rd_used[p], rd_addr[p] != 0 and cnt[rd_addr[p]] != 0.
- WAW hazard: issue_valid and issue_wen and waddr != 0 and cnt[waddr] > issue_lat. This prevents out-of-order completion.
- Stall: stall = (RAW | WAW) & ~flush. It is combinational, with no registered delay.
- Accepted issue: acc = issue_valid & ~stall & ~flush.
- Counter update, every posedge:
  - Every nonzero cnt decrements by 1.
  - If acc and issue_wen and waddr != 0, cnt[waddr] <= issue_lat. The load overrides the decrement for the same register.
- Tracker update, every posedge:
  - Entries shift: entry k+1 <= entry k.
  - Entry 1 <= {acc & issue_wen & (waddr != 0), waddr}. A stalled or flushed issue inserts an invalid bubble.
  - Entry DEPTH falls off the end.
  - The pipeline behind issue never stalls.
- Bypass select: fwd_sel[p] = the smallest k with entry k valid and waddr == rd_addr[p]. It is 0 if there is no match, rd_addr[p] == 0, or rd_used[p] == 0. The select is combinational.
- Worked example: producer issues at cycle t with lat L.
  - A dependent is held for exactly L cycles and issues at t+1+L.
  - At that issue it sees fwd_sel = L+1, provided L+1 <= DEPTH; otherwise fwd_sel = 0 (value already in the GPR).
- issue_lat > DEPTH is illegal. The simulation assertion fires and the value is saturated to DEPTH.
- A flush the same cycle as a hazard gives stall = 0 and no state write.
- Reset mid-stall clears everything immediately; the next issue after reset is never stalled.

Optional Feature:
- Macro: MIPS_HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with stall = 1.
  - It saturates at 32'hFFFF_FFFF and does not wrap.
  - Reset clears it to 0.
- Undefined: perf_stall_cnt is tied to 0 and no counter flops are synthesised.

Test Plan:
- ALU back-to-back: issue add $3 (lat 0), next cycle issue use $3 on port 0 -> stall = 0, fwd_sel[0] = 1.
- Load-use: lw $5 (lat 1) at t, consumer of $5 at t+1 -> stall = 1 for 1 cycle. Consumer issues at t+2 with fwd_sel = 2; pend_mask[5] = 1 only during t+1.
- Multi-cycle with DEPTH = 4: mul $7 lat 4 -> dependent stalls 4 cycles. At issue fwd_sel = 0; cnt[7] reads 4, 3, 2, 1, 0.
- WAW: mul $7 lat 3, then add $7 lat 0 -> add stalls until cnt[7] = 0. A load lat 1 to $7 issued when cnt[7] = 1 is not stalled.
- Register 0 and flush:
  - Writes to $0 are never tracked: pend_mask = 0, no stall for $0 readers.
  - A flush asserted during a RAW stall gives stall = 0 and the squashed write does not set cnt.
- Perf and reset, with MIPS_HAZARD_SCOREBOARD_PERF_EN: 3 load-use stalls -> perf_stall_cnt = 3. Assert rst_n = 0 mid-stall -> stall, cnt and the counter read 0 in the same cycle.
